pmod_jstk_spi: RTL

//  SPI master that polls a PmodJSTK joystick and produces the 10-bit joy_x/joy_y

---
 rtl/pmod_jstk_spi_pkg.sv | 21 ++
 rtl/pmod_jstk_spi_byte_shift.sv | 88 ++++++++
 rtl/pmod_jstk_spi.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pmod_jstk_spi_pkg.sv
// Shared types and constants for the PmodJSTK SPI poller.
package pmod_jstk_spi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SHIFT = 3'd2,
      ST_GAP   = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   localparam logic [5:0] CMD_LED_PREFIX = 6'b100000;
   localparam int JOY_W = 10;
   localparam int BTN_W = 3;

   // Clock cycles from SETUP entry through the DONE cycle for one 5-byte poll.
   function automatic int txn_cycles(input int ss_setup, input int sclk_half, input int byte_gap);
      return ss_setup + 80 * sclk_half + 4 * byte_gap + 1;
   endfunction

endpackage

// File: rtl/pmod_jstk_spi_byte_shift.sv
// One mode-0 SPI byte: first sclk rise on start, 16 half-periods, done on the last cycle.
module pmod_jstk_spi_byte_shift #(
   parameter int SCLK_HALF = 100
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       start,
   input  logic [7:0] tx,
   input  logic       miso,
   output logic       sclk,
   output logic       mosi,
   output logic [7:0] rx,
   output logic       done
);

   localparam int HW = $clog2(SCLK_HALF);
   localparam logic [HW-1:0] HALF_LAST = HW'(SCLK_HALF - 1);

   if (SCLK_HALF < 2) begin : g_half_chk
      $error("pmod_jstk_spi_byte_shift: SCLK_HALF must be at least 2");
   end

   logic          active_q, active_d;
   logic [HW-1:0] half_q, half_d;
   logic [3:0]    edge_q, edge_d;
   logic          sclk_q, sclk_d;
   logic [7:0]    sh_q, sh_d;
   logic          mosi_q, mosi_d;

   // miso arrives through a 2-FF synchroniser, so it is captured as sclk falls: that
   // value is the line state two cycles earlier, i.e. during the high phase.
   always_comb begin
      active_d = active_q;
      half_d   = half_q;
      edge_d   = edge_q;
      sclk_d   = sclk_q;
      sh_d     = sh_q;
      mosi_d   = mosi_q;
      if (!active_q) begin
         mosi_d = tx[7];
         if (start) begin
            active_d = 1'b1;
            half_d   = '0;
            edge_d   = '0;
            sclk_d   = 1'b1;
            sh_d     = tx;
         end
      end else if (half_q != HALF_LAST) begin
         half_d = half_q + HW'(1);
      end else begin
         half_d = '0;
         if (edge_q == 4'd15) begin
            active_d = 1'b0;
         end else begin
            edge_d = edge_q + 4'd1;
            sclk_d = ~sclk_q;
            if (sclk_q) begin
               sh_d   = {sh_q[6:0], miso};
               mosi_d = (edge_q == 4'd14) ? 1'b0 : sh_q[6];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         active_q <= 1'b0;
         half_q   <= '0;
         edge_q   <= '0;
         sclk_q   <= 1'b0;
         sh_q     <= '0;
         mosi_q   <= 1'b0;
      end else begin
         active_q <= active_d;
         half_q   <= half_d;
         edge_q   <= edge_d;
         sclk_q   <= sclk_d;
         sh_q     <= sh_d;
         mosi_q   <= mosi_d;
      end
   end

   assign sclk = sclk_q;
   assign mosi = mosi_q;
   assign rx   = sh_q;
   assign done = active_q && (half_q == HALF_LAST) && (edge_q == 4'd15);

endmodule

// File: rtl/pmod_jstk_spi.sv
// PmodJSTK poller: one 5-byte SPI transaction per poll period, outputs updated atomically in DONE.
module pmod_jstk_spi
   import pmod_jstk_spi_pkg::*;
#(
   parameter int SCLK_HALF   = 100,
   parameter int SS_SETUP    = 1500,
   parameter int BYTE_GAP    = 1000,
   parameter int POLL_PERIOD = 1000000,
   parameter int JOY_INIT    = 512
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [1:0]       leds,
   input  logic             miso,
   output logic             ss,
   output logic             sclk,
   output logic             mosi,
   output logic [JOY_W-1:0] joy_x,
   output logic [JOY_W-1:0] joy_y,
   output logic [BTN_W-1:0] btn,
   output logic             sample_valid,
   output logic             busy,
   output state_e           dbg_state
);

   localparam int PW   = $clog2(POLL_PERIOD);
   localparam int TMAX = (SS_SETUP > BYTE_GAP) ? SS_SETUP : BYTE_GAP;
   localparam int TW   = $clog2(TMAX + 1);
   localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_PERIOD - 1);
   localparam logic [TW-1:0] SETUP_LAST = TW'(SS_SETUP - 1);
   localparam logic [TW-1:0] GAP_LAST   = TW'(BYTE_GAP - 1);

   if (txn_cycles(SS_SETUP, SCLK_HALF, BYTE_GAP) >= POLL_PERIOD) begin : g_period_chk
      $error("pmod_jstk_spi: transaction does not fit in POLL_PERIOD");
   end

   state_e          state_q, state_d;
   logic [PW-1:0]   poll_q, poll_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [2:0]      byte_idx_q, byte_idx_d;
   logic [7:0]      tx_q, tx_d;
   logic            ss_q, ss_d, busy_q, busy_d, sv_q, sv_d;
   logic            miso_meta_q, miso_sync_q;
   logic [7:0]      xlo_q, ylo_q;
   logic [1:0]      xhi_q, yhi_q;
   logic [JOY_W-1:0] joy_x_q, joy_y_q;
   logic [BTN_W-1:0] btn_q;
   logic            start, shift_done;
   logic [7:0]      rx_w;

   pmod_jstk_spi_byte_shift #(.SCLK_HALF(SCLK_HALF)) u_shift (
      .clk   (clk),
      .clr   (clr),
      .start (start),
      .tx    (tx_q),
      .miso  (miso_sync_q),
      .sclk  (sclk),
      .mosi  (mosi),
      .rx    (rx_w),
      .done  (shift_done)
   );

   // The poll counter ignores the FSM so transaction starts stay exactly one period apart.
   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      byte_idx_d = byte_idx_q;
      tx_d       = tx_q;
      start      = 1'b0;
      poll_d     = (poll_q == POLL_LAST) ? '0 : poll_q + PW'(1);
      case (state_q)
         ST_IDLE: if (poll_q == POLL_LAST) begin
            state_d    = ST_SETUP;
            tx_d       = {CMD_LED_PREFIX, leds};
            timer_d    = '0;
            byte_idx_d = '0;
         end
         ST_SETUP: if (timer_q == SETUP_LAST) begin
            state_d = ST_SHIFT;
            start   = 1'b1;
         end else begin
            timer_d = timer_q + TW'(1);
         end
         ST_SHIFT: if (shift_done) begin
            state_d = (byte_idx_q == 3'd4) ? ST_DONE : ST_GAP;
            timer_d = '0;
            tx_d    = 8'h00;
         end
         ST_GAP: if (timer_q == GAP_LAST) begin
            state_d    = ST_SHIFT;
            start      = 1'b1;
            byte_idx_d = byte_idx_q + 3'd1;
         end else begin
            timer_d = timer_q + TW'(1);
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      ss_d   = !(state_d inside {ST_SETUP, ST_SHIFT, ST_GAP});
      busy_d = (state_d != ST_IDLE);
      sv_d   = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q     <= ST_IDLE;
         poll_q      <= '0;
         timer_q     <= '0;
         byte_idx_q  <= '0;
         tx_q        <= '0;
         ss_q        <= 1'b1;
         busy_q      <= 1'b0;
         sv_q        <= 1'b0;
         miso_meta_q <= 1'b0;
         miso_sync_q <= 1'b0;
         xlo_q       <= '0;
         xhi_q       <= '0;
         ylo_q       <= '0;
         yhi_q       <= '0;
         joy_x_q     <= JOY_W'(JOY_INIT);
         joy_y_q     <= JOY_W'(JOY_INIT);
         btn_q       <= '0;
      end else begin
         state_q     <= state_d;
         poll_q      <= poll_d;
         timer_q     <= timer_d;
         byte_idx_q  <= byte_idx_d;
         tx_q        <= tx_d;
         ss_q        <= ss_d;
         busy_q      <= busy_d;
         sv_q        <= sv_d;
         miso_meta_q <= miso;
         miso_sync_q <= miso_meta_q;
         if (shift_done) begin
            case (byte_idx_q)
               3'd0:    xlo_q <= rx_w;
               3'd1:    xhi_q <= rx_w[1:0];
               3'd2:    ylo_q <= rx_w;
               3'd3:    yhi_q <= rx_w[1:0];
               default: begin
                  joy_x_q <= {xhi_q, xlo_q};
                  joy_y_q <= {yhi_q, ylo_q};
                  btn_q   <= rx_w[BTN_W-1:0];
               end
            endcase
         end
      end
   end

   assign ss           = ss_q;
   assign busy         = busy_q;
   assign sample_valid = sv_q;
   assign joy_x        = joy_x_q;
   assign joy_y        = joy_y_q;
   assign btn          = btn_q;
   assign dbg_state    = state_q;

endmodule
